// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: fetches 32-bit MIPS words from instruction memory and
// buffers {pc, instr} pairs in an in-order FIFO for the instruction decoder.
// One fetch request may be outstanding at a time. A backend redirect flushes
// all wrong-path state. A response that was already in flight when the
// redirect arrived is dropped when it returns.
// Optional feature: define IFQ_JUMP_FOLLOW_EN so that fetch follows j/jal
// targets directly. Without it, fetch is strictly sequential.
module instr_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t        state, state_next;
  logic [31:0]   fetch_pc, fetch_pc_next, issued_pc;
  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          req_fire, resp_push, pop;
  logic          jump_take;
  logic [31:0]   jump_target;

  assign imem_req_valid = rst_n & (state == ST_RUN) & (count < FULL_COUNT) & ~redirect_valid;
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid & imem_req_ready;
  assign resp_push      = rst_n & (state == ST_WAIT) & imem_resp_valid & ~redirect_valid;

  assign out_valid = rst_n & (count != '0) & ~redirect_valid;
  assign pop       = out_valid & out_ready;
  assign out_pc    = pc_mem[rd_ptr];
  assign out_instr = instr_mem[rd_ptr];

`ifdef IFQ_JUMP_FOLLOW_EN
  logic [31:0] issued_pc_plus4;
  logic        resp_is_jump;
  assign issued_pc_plus4 = issued_pc + 32'd4;
  assign resp_is_jump    = (imem_resp_data[31:26] == 6'h02) || (imem_resp_data[31:26] == 6'h03);
  assign jump_take       = resp_push & resp_is_jump;
  assign jump_target     = {issued_pc_plus4[31:28], imem_resp_data[25:0], 2'b00};
`else
  assign jump_take   = 1'b0;
  assign jump_target = fetch_pc;
`endif

  // Next fetch address: a redirect wins, then sequential advance on accept, then a followed jump
  always_comb begin
    fetch_pc_next = fetch_pc;
    if (redirect_valid) begin
      fetch_pc_next = redirect_pc & ~32'd3;
    end else if (req_fire) begin
      fetch_pc_next = fetch_pc + 32'd4;
    end else if (jump_take) begin
      fetch_pc_next = jump_target;
    end
  end

  // Fetch FSM next state: a redirect while waiting turns the in-flight response into wrong-path
  always_comb begin
    state_next = state;
    case (state)
      ST_RUN: begin
        if (req_fire) state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (imem_resp_valid)     state_next = ST_RUN;
        else if (redirect_valid) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (imem_resp_valid) state_next = ST_RUN;
      end
      default: state_next = ST_RUN;
    endcase
  end

  // FSM state, fetch PC and the PC of the request currently in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_RUN;
      fetch_pc  <= RESET_PC;
      issued_pc <= RESET_PC;
    end else begin
      state    <= state_next;
      fetch_pc <= fetch_pc_next;
      if (req_fire) issued_pc <= fetch_pc;
    end
  end

  // FIFO bookkeeping; a redirect empties the queue in a single cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (redirect_valid) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (resp_push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)       rd_ptr <= rd_ptr + PW'(1);
      case ({resp_push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage; entries are only read while count marks them valid, so no reset is needed
  always_ff @(posedge clk) begin
    if (resp_push) begin
      pc_mem[wr_ptr]    <= issued_pc;
      instr_mem[wr_ptr] <= imem_resp_data;
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb_instr_fetch_queue: randomized scoreboard bench for instr_fetch_queue.
// The reference model is the program stream: from each reset or redirect
// target, the decoder must see consecutive words of a fixed memory image
// (following j/jal when IFQ_JUMP_FOLLOW_EN is defined).
module tb_instr_fetch_queue;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam int          DEPTH    = 4;

`ifdef IFQ_JUMP_FOLLOW_EN
  localparam logic [31:0] STALL_ADDR  = 32'h0000_3100;
  localparam logic [31:0] RESUME_ADDR = 32'h0000_310C;
  localparam logic [31:0] THIRD_ADDR  = 32'h0000_3104;
`else
  localparam logic [31:0] STALL_ADDR  = 32'h0000_3004;
  localparam logic [31:0] RESUME_ADDR = 32'h0000_3010;
  localparam logic [31:0] THIRD_ADDR  = 32'h0000_3008;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid, out_ready;
  logic [31:0] out_pc, out_instr;

  instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          lat_cfg = 1;
  int          pop_count = 0;
  logic [31:0] last_pop_pc = '0;
  logic [31:0] model_pc;
  logic [31:0] exp_pc_q[$];
  logic [31:0] exp_instr_q[$];
  logic [31:0] pend_addr_q[$];
  int          pend_due_q[$];
  logic [31:0] fire_log[$];
  logic        prev_stall = 1'b0;
  logic [31:0] prev_addr = '0;

  // Fixed instruction memory image; only 0x3000 holds a jump (jal 0x3100)
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    if (a == 32'h0000_3000) return 32'h0C00_0C40;
    w = (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
    if (w[31:26] == 6'h02 || w[31:26] == 6'h03) w[31] = 1'b1;
    return w;
  endfunction

  // Program-order successor of a fetched word
  function automatic logic [31:0] next_pc(input logic [31:0] pc, input logic [31:0] w);
    logic [31:0] pc4;
    pc4 = pc + 32'd4;
`ifdef IFQ_JUMP_FOLLOW_EN
    if (w[31:26] == 6'h02 || w[31:26] == 6'h03) return {pc4[31:28], w[25:0], 2'b00};
`endif
    return pc4;
  endfunction

  function automatic void extend_stream(input int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] w;
      w = mem_word(model_pc);
      exp_pc_q.push_back(model_pc);
      exp_instr_q.push_back(w);
      model_pc = next_pc(model_pc, w);
    end
  endfunction

  function automatic void build_stream(input logic [31:0] start);
    exp_pc_q.delete();
    exp_instr_q.delete();
    model_pc = start;
    extend_stream(16);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // One clock of stimulus; the memory model answers the oldest accepted request once its latency has elapsed
  task automatic applyStimulus(input bit rst_v, input bit rdy_o, input bit rdy_r,
                               input bit redir, input logic [31:0] rpc);
    @(posedge clk);
    #1;
    cyc++;
    rst_n          = ~rst_v;
    out_ready      = rdy_o;
    imem_req_ready = rdy_r;
    redirect_valid = redir;
    redirect_pc    = rpc;
    if (rst_v) begin
      pend_addr_q.delete();
      pend_due_q.delete();
      build_stream(RESET_PC);
    end else if (redir) begin
      build_stream(rpc & ~32'd3);
    end
    imem_resp_valid = !rst_v && (pend_addr_q.size() > 0) && (pend_due_q[0] <= cyc);
    imem_resp_data  = imem_resp_valid ? mem_word(pend_addr_q[0]) : $urandom;
  endtask

  // Monitor: scoreboard pops, handshake rules and memory-side bookkeeping
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (redirect_valid) begin
        checkOutput("out_valid_in_redirect", 32'(out_valid), 32'd0);
        checkOutput("req_valid_in_redirect", 32'(imem_req_valid), 32'd0);
      end else if (prev_stall) begin
        checkOutput("req_hold_valid", 32'(imem_req_valid), 32'd1);
        checkOutput("req_hold_addr", imem_req_addr, prev_addr);
      end
      if (dut.resp_push) checkOutput("push_into_full", 32'(dut.count), 32'(dut.count < 3'(DEPTH) ? dut.count : 3'd0));
      if (out_valid && out_ready) begin
        if (exp_pc_q.size() < 4) extend_stream(16);
        checkOutput("out_pc", out_pc, exp_pc_q[0]);
        checkOutput("out_instr", out_instr, exp_instr_q[0]);
        void'(exp_pc_q.pop_front());
        void'(exp_instr_q.pop_front());
        pop_count++;
        last_pop_pc = out_pc;
      end
      if (imem_resp_valid && pend_addr_q.size() > 0) begin
        void'(pend_addr_q.pop_front());
        void'(pend_due_q.pop_front());
      end
      if (imem_req_valid && imem_req_ready) begin
        pend_addr_q.push_back(imem_req_addr);
        pend_due_q.push_back(cyc + lat_cfg);
        fire_log.push_back(imem_req_addr);
      end
      prev_stall = imem_req_valid && !imem_req_ready;
      prev_addr  = imem_req_addr;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic doReset();
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
    @(negedge clk); #1;
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_req_valid", 32'(imem_req_valid), 32'd0);
    fire_log.delete();
  endtask

  // Run until a request for addr is accepted, then redirect to 0x3100 (low bits set to prove they are ignored)
  task automatic redirectTest(input string name, input int lat, input logic [31:0] addr);
    bit found;
    int base;
    doReset();
    lat_cfg = lat;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
      @(negedge clk); #1;
      if (fire_log.size() > 0 && fire_log[fire_log.size()-1] == addr) found = 1'b1;
    end
    if (!found) checkOutput({name, "_fire_timeout"}, 32'd0, 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_3103);
    base  = pop_count;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
      @(negedge clk); #1;
      if (pop_count != base) found = 1'b1;
    end
    checkOutput({name, "_first_pc"}, found ? last_pop_pc : 32'hDEAD_BEEF, 32'h0000_3100);
  endtask

  initial begin
    int base;
    bit found;
    rst_n = 1'b0; out_ready = 1'b1; imem_req_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = '0;
    imem_resp_valid = 1'b0; imem_resp_data = '0;
    build_stream(RESET_PC);

    // Reset release, first request, then a 3-cycle request stall on the second fetch
    doReset();
    lat_cfg = 1;
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
    @(negedge clk); #1;
    checkOutput("first_req_valid", 32'(imem_req_valid), 32'd1);
    checkOutput("first_req_addr", imem_req_addr, RESET_PC);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
      @(negedge clk); #1;
      checkOutput("stall_req_valid", 32'(imem_req_valid), 32'd1);
      checkOutput("stall_req_addr", imem_req_addr, STALL_ADDR);
    end
    for (int i = 0; i < 12; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);

    // Fill to capacity with the decoder stalled, then drain
    doReset();
    lat_cfg = 1;
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
    @(negedge clk); #1;
    checkOutput("full_req_valid", 32'(imem_req_valid), 32'd0);
    checkOutput("full_out_valid", 32'(out_valid), 32'd1);
    checkOutput("full_fire_count", 32'(fire_log.size()), 32'(DEPTH));
    fire_log.delete();
    base = pop_count;
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
    @(negedge clk); #1;
    checkOutput("drain_pops", 32'(pop_count - base), 32'd4);
    checkOutput("resume_addr", (fire_log.size() > 0) ? fire_log[0] : 32'hDEAD_BEEF, RESUME_ADDR);

    // Redirect with the wrong-path response arriving later, then coincident with it
    redirectTest("redir_late", 3, THIRD_ADDR);
    redirectTest("redir_coincident", 1, THIRD_ADDR);

    // Reset while three entries are held and a fourth request is in flight
    doReset();
    lat_cfg = 2;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
      @(negedge clk); #1;
      if (fire_log.size() == 4) found = 1'b1;
    end
    if (!found) checkOutput("midreset_fill_timeout", 32'd0, 32'd1);
    doReset();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
    @(negedge clk); #1;
    checkOutput("midreset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midreset_req_addr", imem_req_addr, RESET_PC);
    checkOutput("midreset_req_valid", 32'(imem_req_valid), 32'd1);

    // Randomized traffic: latencies, backpressure, redirects (some near the 2^32 wrap) and resets
    base = pop_count;
    for (int i = 0; i < 4000; i++) begin
      bit          r, d;
      logic [31:0] rpc;
      lat_cfg = $urandom_range(1, 3);
      r   = ($urandom_range(0, 399) == 0);
      d   = !r && ($urandom_range(0, 29) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      applyStimulus(r, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, d, rpc);
    end
    @(negedge clk); #1;
    checkOutput("random_progress", 32'(pop_count - base > 500), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
